// File: rtl/wb_mem_preloader.sv
// ============================================================================
// wb_mem_preloader : Wishbone master that zero-fills and loads memory, holding the CPU in reset
// Optional readback check of each loaded word: PRELOADER_VERIFY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_mem_preloader #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_WORDS = 32'h00800000,
  parameter int RST_HOLD  = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            start_i,
  input  logic            clear_i,
  input  logic [AW-1:0]   load_words_i,
  input  logic [DW-1:0]   src_data_i,
  input  logic            src_valid_i,
  output logic            src_ready_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            cpu_rst_o,
  output logic [AW-1:0]   words_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_VERIFY, S_HOLD, S_DONE, S_ERROR
  } state_t;

  localparam logic [AW-1:0] C_ONE       = AW'(1);
  localparam logic [AW-1:0] C_MEM_LIMIT = AW'(MEM_WORDS);
  localparam logic [AW-1:0] C_LAST_WORD = AW'(MEM_WORDS - 1);
  localparam logic [AW-1:0] C_BPW       = AW'(DW / 8);
  localparam logic [7:0]    C_HOLD_LAST = 8'(RST_HOLD - 1);

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d, idx_q, idx_d, words_q, words_d, nload_q, nload_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [7:0]      hold_q, hold_d;
  logic            err_q, err_d, done_q, done_d, cpu_rst_q, cpu_rst_d;
  logic            w_src_ready, w_ack, w_err;

  // err takes priority over a coincident ack; both ignored with no cycle open
  assign w_err = cyc_q & wbm_err_i;
  assign w_ack = cyc_q & wbm_ack_i & ~wbm_err_i;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    idx_d       = idx_q;
    words_d     = words_q;
    nload_d     = nload_q;
    hold_d      = hold_q;
    err_d       = err_q;
    done_d      = done_q;
    cpu_rst_d   = cpu_rst_q;
    w_src_ready = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          err_d     = 1'b0;
          done_d    = 1'b0;
          cpu_rst_d = 1'b1;
          idx_d     = '0;
          words_d   = '0;
          hold_d    = '0;
          nload_d   = load_words_i;
          if (load_words_i > C_MEM_LIMIT) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (clear_i) begin
            state_d = S_CLEAR;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = '0;
            dat_d   = '0;
          end else if (load_words_i != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_CLEAR: begin
        if (w_err) begin
          state_d = S_ERROR;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else if (w_ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          words_d = words_q + C_ONE;
          idx_d   = idx_q + C_ONE;
          if (idx_q == C_LAST_WORD) begin
            idx_d   = '0;
            words_d = '0;
            state_d = (nload_q == '0) ? S_HOLD : S_LOAD;
          end
        end else if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = idx_q * C_BPW;
          dat_d = '0;
        end
      end

      S_LOAD: begin
        w_src_ready = !cyc_q && (idx_q < nload_q);
        if (w_err) begin
          state_d = S_ERROR;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else if (w_ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          words_d = words_q + C_ONE;
`ifdef PRELOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          idx_d   = idx_q + C_ONE;
          if (idx_q == nload_q - C_ONE) state_d = S_HOLD;
`endif
        end else if (w_src_ready && src_valid_i) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = idx_q * C_BPW;
          dat_d = src_data_i;
        end
      end

`ifdef PRELOADER_VERIFY_EN
      // adr/dat still hold the word just written; read it back and compare
      S_VERIFY: begin
        if (w_err) begin
          state_d = S_ERROR;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
        end else if (w_ack) begin
          cyc_d = 1'b0;
          if (wbm_dat_i != dat_q) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            words_d = idx_q;
          end else begin
            idx_d   = idx_q + C_ONE;
            state_d = (idx_q == nload_q - C_ONE) ? S_HOLD : S_LOAD;
          end
        end else if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
        end
      end
`endif

      S_HOLD: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == C_HOLD_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      idx_q     <= '0;
      words_q   <= '0;
      nload_q   <= '0;
      hold_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      idx_q     <= idx_d;
      words_q   <= words_d;
      nload_q   <= nload_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

`ifndef PRELOADER_VERIFY_EN
  logic w_unused_dat;
  assign w_unused_dat = ^wbm_dat_i;
`endif

  assign src_ready_o = w_src_ready;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = '1;
  assign wbm_we_o    = we_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign words_o     = words_q;

endmodule

`default_nettype wire
